// File: rtl/i2c_pkg.sv
// Shared types and constants for the write-only I2C master.
// The transaction FSM states, default parameters and quarter-phase numbering live here.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP,
    DONE
  } state_t;

  localparam int         DEFAULT_CLK_DIV    = 250;
  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h55;
  localparam int         DEFAULT_NUM_BYTES  = 5;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // START spans two quarters; running it on Q2/Q3 lets the quarter index wrap
  // naturally into Q0 of the first bit, so every later phase stays aligned.
  localparam logic [1:0] START_FIRST_QUARTER = Q2;

  // SCL is low for the first half of every 4-quarter phase and high otherwise.
  function automatic logic scl_level(input state_t s, input logic [1:0] q);
    case (s)
      BIT, ACK, STOP: return q[1];
      default:        return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Divides the system clock into SCL quarter-periods: a one-cycle tick at the
// end of each quarter plus a 2-bit quarter index that advances on every tick.
module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  // A cleared counter restarts on the START quarter so the first bit lands on Q0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      quarter <= Q0;
    end else if (clear) begin
      count   <= '0;
      quarter <= START_FIRST_QUARTER;
    end else if (enable) begin
      if (tick) begin
        count   <= '0;
        quarter <= quarter + 2'd1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_master_tx.sv
// Write-only I2C master: START, address+W, NUM_BYTES data bytes with ACK checks, STOP.
// Bus lines are driven from registered state so SCL/SDA never glitch.
module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV    = DEFAULT_CLK_DIV,
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
  parameter int         NUM_BYTES  = DEFAULT_NUM_BYTES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] tx_data,
  output logic                   busy,
  output logic                   done,
  output logic                   ack_err,
  output logic                   SCL,
  inout  wire                    SDA
);

  localparam int BCW = $clog2(NUM_BYTES + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NUM_BYTES);

  state_t                 state, state_next;
  logic                   tick;
  logic [1:0]             quarter;
  logic                   accept;
  logic                   sda_in;
  logic [2:0]             bit_cnt, bit_cnt_next;
  logic [BCW-1:0]         byte_cnt, byte_cnt_next;
  logic [7:0]             shift, shift_next;
  logic [8*NUM_BYTES-1:0] data_q, data_next;
  logic                   sda_low, sda_low_next;
  logic                   nack, nack_next;
  logic                   ack_err_next;

  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE) && (state != DONE);
  assign done   = (state == DONE);
  assign SCL    = scl_level(state, quarter);
  assign SDA    = sda_low ? 1'b0 : 1'bz;
  assign sda_in = SDA;

  i2c_quarter_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_quarter_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (busy),
    .clear  (accept),
    .tick   (tick),
    .quarter(quarter)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shift    <= '0;
      data_q   <= '0;
      sda_low  <= 1'b0;
      nack     <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      byte_cnt <= byte_cnt_next;
      shift    <= shift_next;
      data_q   <= data_next;
      sda_low  <= sda_low_next;
      nack     <= nack_next;
      ack_err  <= ack_err_next;
    end
  end

  // On each quarter tick, sda_low is loaded with the level for the quarter
  // that is about to begin; quarters that "hold" SDA simply leave it alone.
  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    byte_cnt_next = byte_cnt;
    shift_next    = shift;
    data_next     = data_q;
    sda_low_next  = sda_low;
    nack_next     = nack;
    ack_err_next  = ack_err;

    case (state)
      IDLE: begin
        if (start) begin
          state_next    = START;
          shift_next    = {SLAVE_ADDR, 1'b0};
          data_next     = tx_data;
          bit_cnt_next  = '0;
          byte_cnt_next = '0;
          sda_low_next  = 1'b0;
          nack_next     = 1'b0;
          ack_err_next  = 1'b0;
        end
      end

      START: begin
        if (tick) begin
          if (quarter == Q2) sda_low_next = 1'b1;
          else               state_next   = BIT;
        end
      end

      BIT: begin
        if (tick) begin
          case (quarter)
            Q0: sda_low_next = ~shift[7];
            Q3: begin
              if (bit_cnt == 3'd7) begin
                bit_cnt_next = '0;
                state_next   = ACK;
              end else begin
                bit_cnt_next = bit_cnt + 3'd1;
                shift_next   = {shift[6:0], 1'b0};
              end
            end
            default: ;
          endcase
        end
      end

      // The slave's answer is taken on the last clock of the second SCL-high
      // quarter's predecessor, well after it has settled.
      ACK: begin
        if (tick) begin
          case (quarter)
            Q0: sda_low_next = 1'b0;
            Q2: nack_next    = sda_in;
            Q3: begin
              if (nack) begin
                ack_err_next = 1'b1;
                state_next   = STOP;
              end else if (byte_cnt == LAST_BYTE) begin
                state_next = STOP;
              end else begin
                byte_cnt_next = byte_cnt + 1'b1;
                shift_next    = data_q[7:0];
                data_next     = data_q >> 8;
                state_next    = BIT;
              end
            end
            default: ;
          endcase
        end
      end

      STOP: begin
        if (tick) begin
          case (quarter)
            Q0: sda_low_next = 1'b1;
            Q2: sda_low_next = 1'b0;
            Q3: state_next   = DONE;
            default: ;
          endcase
        end
      end

      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_tx.sv
// Self-checking bench: a bus-level slave model plus a quarter-by-quarter
// waveform model of the expected SCL/SDA/busy/done behaviour.
module tb_i2c_master_tx;
  import i2c_pkg::*;

  localparam int DIV = 4;
  localparam int NB  = 5;
  localparam logic [6:0] DUT_ADDR = 7'h55;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [8*NB-1:0] tx_data = '0;
  logic            busy, done, ack_err, scl;
  wire             sda;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pullup (sda);

  i2c_master_tx #(
    .CLK_DIV   (DIV),
    .SLAVE_ADDR(DUT_ADDR),
    .NUM_BYTES (NB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .tx_data(tx_data),
    .busy   (busy),
    .done   (done),
    .ack_err(ack_err),
    .SCL    (scl),
    .SDA    (sda)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Bus-level slave: acks its own address and every data byte, storing byte k in register k.
  logic [6:0] slave_addr = 7'h55;
  logic [7:0] sl_regs [0:7];
  logic [7:0] sl_shift;
  bit sl_active, sl_is_addr, sl_in_ack, sl_ack_pending, sl_drive;
  int sl_bits, sl_ptr;

  assign sda = (sl_drive && !reset) ? 1'b0 : 1'bz;

  task automatic slaveReset();
    sl_active = 0; sl_is_addr = 0; sl_in_ack = 0; sl_ack_pending = 0; sl_drive = 0;
    sl_bits = 0; sl_ptr = 0; sl_shift = '0;
    for (int i = 0; i < 8; i++) sl_regs[i] = '0;
  endtask

  always @(negedge sda) if (scl === 1'b1 && !reset) begin
    sl_active = 1; sl_is_addr = 1; sl_bits = 0; sl_ptr = 0;
    sl_in_ack = 0; sl_ack_pending = 0; sl_drive = 0;
  end

  always @(posedge sda) if (scl === 1'b1 && !reset) begin
    sl_active = 0; sl_drive = 0;
  end

  always @(posedge scl) if (sl_active && !reset && !sl_in_ack) begin
    sl_shift = {sl_shift[6:0], sda};
    sl_bits++;
    if (sl_bits == 8) begin
      sl_bits = 0;
      if (sl_is_addr) begin
        sl_is_addr = 0;
        if (sl_shift == {slave_addr, 1'b0}) sl_ack_pending = 1;
        else sl_active = 0;
      end else begin
        if (sl_ptr < 8) sl_regs[sl_ptr] = sl_shift;
        sl_ptr++;
        sl_ack_pending = 1;
      end
    end
  end

  always @(negedge scl) if (!reset) begin
    if (sl_ack_pending) begin
      sl_drive = 1; sl_ack_pending = 0; sl_in_ack = 1;
    end else if (sl_in_ack) begin
      sl_drive = 0; sl_in_ack = 0;
    end
  end

  // Expected bus levels, one entry per SCL quarter, built from the protocol rules.
  bit exp_scl[$];
  bit exp_sda[$];
  bit model_nack;
  bit model_armed = 0;

  task automatic pushQ(input bit s, input bit d);
    exp_scl.push_back(s);
    exp_sda.push_back(d);
  endtask

  task automatic buildModel(input logic [8*NB-1:0] data, input bit addr_ack);
    logic [7:0] bytes [$];
    bit level, ack, v;
    exp_scl.delete();
    exp_sda.delete();
    bytes.push_back({DUT_ADDR, 1'b0});
    for (int k = 0; k < NB; k++) bytes.push_back(data[8*k +: 8]);
    pushQ(1, 1); pushQ(1, 0);
    level = 0;
    for (int b = 0; b < bytes.size(); b++) begin
      for (int i = 7; i >= 0; i--) begin
        v = bytes[b][i];
        pushQ(0, level); pushQ(0, v); pushQ(1, v); pushQ(1, v);
        level = v;
      end
      ack = (b == 0) ? addr_ack : 1'b1;
      if (ack) begin
        pushQ(0, 0); pushQ(0, 0); pushQ(1, 0); pushQ(1, 0);
      end else begin
        pushQ(0, level); pushQ(0, 1); pushQ(1, 1); pushQ(1, 1);
      end
      level = 1;
      if (!ack) break;
    end
    pushQ(0, level); pushQ(0, 0); pushQ(1, 0); pushQ(1, 1);
    model_nack = !addr_ack;
  endtask

  // Compare process: checks every cycle against the model, or idle levels between transactions.
  bit running = 0;
  bit exp_ackerr = 0;
  int run_idx = 0;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      running = 0;
      model_armed = 0;
      exp_ackerr = 0;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_ackerr", ack_err, 0);
      checkOutput("rst_scl", scl, 1);
      checkOutput("rst_sda", sda, 1);
    end else begin
      if (!running && start && model_armed) begin
        running = 1;
        model_armed = 0;
        run_idx = 0;
      end
      if (running) begin
        if (run_idx < exp_scl.size() * DIV) begin
          checkOutput("run_busy", busy, 1);
          checkOutput("run_done", done, 0);
          checkOutput("run_scl", scl, exp_scl[run_idx / DIV]);
          checkOutput("run_sda", sda, exp_sda[run_idx / DIV]);
          if (run_idx == 0) checkOutput("accept_ackerr", ack_err, 0);
        end else begin
          checkOutput("end_done", done, 1);
          checkOutput("end_busy", busy, 0);
          checkOutput("end_scl", scl, 1);
          checkOutput("end_sda", sda, 1);
          checkOutput("end_ackerr", ack_err, model_nack);
          exp_ackerr = model_nack;
          running = 0;
        end
        run_idx++;
      end else begin
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_done", done, 0);
        checkOutput("idle_scl", scl, 1);
        checkOutput("idle_sda", sda, 1);
        checkOutput("idle_ackerr", ack_err, exp_ackerr);
      end
    end
  end

  // Protocol monitor: SCL half-period lengths and SDA activity while SCL is high.
  bit pm_scl, pm_sda, pm_after_low;
  int pm_run, pm_hi_edges;
  int done_pulses = 0;

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_pulses++;
    if (reset) begin
      pm_run = 0; pm_hi_edges = 0; pm_after_low = 0; pm_scl = 1; pm_sda = 1;
    end else begin
      if (scl === pm_scl) pm_run++;
      else begin
        if (pm_scl == 0) checkOutput("scl_low_len", pm_run, 2*DIV);
        else if (pm_after_low) checkOutput("scl_high_len", pm_run, 2*DIV);
        if (pm_scl == 0) pm_after_low = 1;
        pm_run = 1;
      end
      if (scl && pm_scl && sda !== pm_sda) pm_hi_edges++;
      if (done === 1'b1) begin
        checkOutput("sda_edges_scl_high", pm_hi_edges, 2);
        pm_hi_edges = 0;
        pm_after_low = 0;
      end
      pm_scl = scl;
      pm_sda = sda;
    end
  end

  task automatic applyStimulus(input logic [8*NB-1:0] data, input bit addr_ack);
    buildModel(data, addr_ack);
    @(negedge clk);
    tx_data = data;
    model_armed = 1;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // Counts cycles from the first busy cycle until done is seen (bounded).
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (cycles < 4000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done === 1'b1) break;
    end
  endtask

  localparam logic [8*NB-1:0] PAY_A = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
  localparam logic [8*NB-1:0] PAY_B = {8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
  localparam logic [8*NB-1:0] PAY_C = {8'h81, 8'h0F, 8'hF0, 8'h3C, 8'h5A};

  int cyc, pulses_before;
  logic [8*NB-1:0] pay;

  initial begin
    slaveReset();
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (5) @(negedge clk);

    $display("[TB] address NACK");
    slave_addr = 7'h50;
    applyStimulus(PAY_A, 0);
    checkOutput("model_len_nack", exp_scl.size(), 42);
    waitDone(cyc);
    checkOutput("nack_latency", cyc, 168);
    checkOutput("nack_ackerr", ack_err, 1);
    checkOutput("nack_reg0", sl_regs[0], 8'h00);
    checkOutput("nack_reg4", sl_regs[4], 8'h00);
    repeat (10) @(negedge clk);

    $display("[TB] normal transfer");
    slave_addr = 7'h55;
    applyStimulus(PAY_A, 1);
    checkOutput("model_len_full", exp_scl.size(), 222);
    waitDone(cyc);
    checkOutput("full_latency", cyc, 888);
    checkOutput("full_ackerr", ack_err, 0);
    pay = PAY_A;
    for (int k = 0; k < NB; k++) checkOutput("full_reg", sl_regs[k], pay[8*k +: 8]);
    repeat (3) @(negedge clk);

    $display("[TB] back-to-back transfer");
    applyStimulus(PAY_B, 1);
    waitDone(cyc);
    checkOutput("b2b_latency", cyc, 888);
    checkOutput("b2b_reg0", sl_regs[0], 8'h01);
    checkOutput("b2b_reg4", sl_regs[4], 8'h05);
    checkOutput("b2b_ackerr", ack_err, 0);
    repeat (5) @(negedge clk);

    $display("[TB] start and tx_data change while busy");
    pulses_before = done_pulses;
    applyStimulus(PAY_A, 1);
    repeat (99) @(negedge clk);
    start = 1;
    tx_data = {NB{8'hAA}};
    @(negedge clk);
    start = 0;
    waitDone(cyc);
    repeat (20) @(negedge clk);
    checkOutput("busy_start_pulses", done_pulses - pulses_before, 1);
    for (int k = 0; k < NB; k++) checkOutput("busy_start_reg", sl_regs[k], pay[8*k +: 8]);

    $display("[TB] reset mid-transaction");
    applyStimulus(PAY_B, 1);
    repeat (299) @(negedge clk);
    reset = 1;
    slaveReset();
    @(negedge clk);
    checkOutput("midrst_scl", scl, 1);
    checkOutput("midrst_sda", sda, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_ackerr", ack_err, 0);
    reset = 0;
    repeat (5) @(negedge clk);
    applyStimulus(PAY_C, 1);
    waitDone(cyc);
    checkOutput("post_rst_latency", cyc, 888);
    pay = PAY_C;
    for (int k = 0; k < NB; k++) checkOutput("post_rst_reg", sl_regs[k], pay[8*k +: 8]);
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_tx.md
Name: i2c_master_tx

Overview:
- Write-only I2C bus master that feeds the camera-side I2C slave register block.
- On a start request it issues START, address byte {SLAVE_ADDR, W=0}, then NUM_BYTES data bytes, checking ACK after each, then STOP.
- Byte k lands in slave register k.
- Sits in the control FPGA between the command logic that produces the tx_data payload and the physical SCL/SDA pins.

Parameters:
- CLK_DIV, 250: system clocks per SCL quarter-period (100 MHz → 100 kHz). Legal range ≥ 4, so the slave's 2-stage synchronisers see each edge within one quarter.
- SLAVE_ADDR, 7'h55: 7-bit target address.
- NUM_BYTES, 5: data bytes per transaction (1..8).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  transaction request; sampled when busy=0
- tx_data  input  8*NUM_BYTES  payload; byte k at [8k+7:8k], byte 0 sent first, MSB first
- busy  output  1  high from accepted start to end of STOP
- done  output  1  one-cycle pulse at end of transaction (success or NACK)
- ack_err  output  1  set on any NACK; held until the next accepted start
- SCL  output  1  bus clock, push-pull, idles 1
- SDA  inout  1  open-drain: driven 0 or released (z); external/bench pull-up

Behaviour:
- Reset (synchronous): state IDLE, SCL=1, SDA released, busy=0, done=0, ack_err=0, counters 0. Reset mid-transaction takes effect at the next clk edge; bus lines return to idle immediately with no STOP generated.
- start with busy=0 (cycle t):
  - tx_data is latched and ack_err is cleared.
  - busy=1 from t+1.
  - start while busy=1 is ignored; later tx_data changes have no effect.
- A quarter-tick counter counts 0..CLK_DIV-1 and advances the quarter index on wrap. Each phase below lasts an exact number of quarters.
- START (2 quarters): q0 SCL=1 SDA=1; q1 SCL=1 SDA=0.
- BIT (4 quarters, used for all 8 bits of every byte):
  - q0 SCL=0, SDA holds its previous level. This keeps SDA low at the first falling edge so the slave detects START.
  - q1 SCL=0, SDA=bit (0 → drive low, 1 → release).
  - q2, q3 SCL=1.
- ACK (4 quarters):
  - q0 SCL=0, SDA held; q1 release SDA; q2, q3 SCL=1.
  - SDA is sampled on the last clk of q2.
  - 0 → continue with the next byte, or STOP after byte NUM_BYTES.
  - 1 → ack_err=1, skip the remaining bytes, go to STOP.
- After an ACK, the next byte's q0 keeps SDA released.
- STOP (4 quarters): q0 SCL=0 SDA held; q1 SCL=0 SDA=0; q2 SCL=1 SDA=0; q3 SCL=1 SDA released.
- DONE: at the end of STOP q3, done=1 for one cycle and busy=0 in the same cycle. start is accepted again from the next cycle.
- Byte sequence: the address byte (SLAVE_ADDR<<1 | 0) goes first, then tx_data bytes 0..NUM_BYTES-1. A bit counter runs 0..7 and a byte counter runs 0..NUM_BYTES.
- Full transaction length: 2 + (NUM_BYTES+1)*36 + 4 quarters. With defaults that is 222 quarters. done fires exactly 222*CLK_DIV cycles after busy rises.
- NACK on the address byte: length is 2+36+4 = 42 quarters.
- SDA never changes while SCL=1, except the START edge (q1) and STOP edge (q3).
- States: IDLE, START, BIT, ACK, STOP, DONE.

Decomposition:
- Package i2c_pkg holds:
  - the state enum;
  - the default slave address 7'h55;
  - the default byte count 5;
  - the quarter-phase constants.
- One sub-module, i2c_quarter_tick: a CLK_DIV counter that emits a one-cycle tick plus a 2-bit quarter index. It is enabled while busy and cleared on start/reset.
- The FSM and shifters live in the top.

Test Plan:
1. CLK_DIV=4, master connected to the I2C slave block, tx_data bytes 0..4 = 11,22,33,44,55 (hex), pulse start → slave registers 0..4 = 11,22,33,44,55; ack_err=0; done exactly 888 cycles after busy rises; slave go_right=1.
2. SLAVE_ADDR=7'h50, same payload → slave NACKs the address; ack_err=1; done 168 cycles after busy rises; slave registers stay 0.
3. Pulse start again at cycle 100 of a transaction and change tx_data to all AA → ignored; slave still receives 11..55; exactly one done pulse.
4. Assert reset at cycle 300 of a transaction → next cycle SCL=1, SDA=1 (pulled up), busy=0, done=0, ack_err=0; a new start then completes a normal transfer once the slave is reset.
5. Back-to-back: after test 1, pulse the slave's responsing_i2c, then start with 01..05 → slave registers 0..4 = 01..05; ack_err=0.
6. Protocol monitor across all tests → SDA changes while SCL=1 only at START/STOP; each SCL high/low half is exactly 2*CLK_DIV cycles.
